// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Also carries the CPU data-bus access-size type.
package uart_mmio_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd3,
    MEM_HU = 3'd4
  } mem_op_t;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] DIV_OFF    = 4'h8;
  localparam logic [3:0] RSVD_OFF   = 4'hC;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  function automatic logic [3:0] sat_cnt4(
    input logic [31:0] c
  );
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by the UART register window.
// Same signal set as data_memory.
interface mmio_uart_tx_if;
  import uart_mmio_pkg::*;

  logic        wr_en;
  mem_op_t     mem_ctrl;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output wr_en,
    output mem_ctrl,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  wr_en,
    input  mem_ctrl,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Register window: TXDATA, STATUS, DIVISOR, reserved.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic           clk,
  input  logic           resetn,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           hit;
  logic [1:0]     sel;
  logic           wr_tx;
  logic           wr_st;
  logic           wr_div;

  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  logic           ovf_q;
  logic [15:0]    div_reg_q;
  logic [31:0]    status;
  logic [31:0]    rd_data;

  uart_tx_state_t state_q;
  uart_tx_state_t state_d;
  logic [15:0]    cnt_q;
  logic [15:0]    div_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           tx_d;
  logic           tick;
  logic           load;

  logic           unused;

  assign hit    = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel    = bus.addr[3:2];
  assign wr_tx  = bus.wr_en && hit && (sel == TXDATA_OFF[3:2]);
  assign wr_st  = bus.wr_en && hit && (sel == STATUS_OFF[3:2]);
  assign wr_div = bus.wr_en && hit && (sel == DIV_OFF[3:2]);

  assign fifo_push = wr_tx && !fifo_full;
  assign fifo_pop  = load;

  assign unused = ^{bus.mem_ctrl, bus.addr[1:0], bus.data_in[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (bus.data_in[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q     <= 1'b0;
      div_reg_q <= DEFAULT_DIV;
    end else begin
      if (wr_tx && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_st && bus.data_in[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (wr_div) begin
        div_reg_q <= (bus.data_in[15:0] == 16'd0) ?
                     16'd1 : bus.data_in[15:0];
      end
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_BUSY]        = (state_q != IDLE) || !fifo_empty;
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_OVF]         = ovf_q;
    status[ST_CNT_LO+:4]   = sat_cnt4(32'(fifo_count));
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      unique case (sel)
        STATUS_OFF[3:2]: rd_data = status;
        DIV_OFF[3:2]:    rd_data = {16'd0, div_reg_q};
        default:         rd_data = '0;
      endcase
    end
  end

  assign bus.data_out = rd_data;

  assign tick = (cnt_q == div_q - 16'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick && bit_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = fifo_empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    tx_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        load = !fifo_empty;
        tx_d = 1'b1;
      end
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_q[0];
      STOP: begin
        load = tick && !fifo_empty;
        tx_d = 1'b1;
      end
      default: begin
        load = 1'b0;
        tx_d = 1'b1;
      end
    endcase
  end

  // tx is registered off the current state, so the line trails it by one clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      div_q   <= DEFAULT_DIV;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (load) begin
        shift_q <= fifo_rdata;
        div_q   <= div_reg_q;
        cnt_q   <= '0;
        bit_q   <= '0;
      end else if (state_q != IDLE) begin
        if (tick) begin
          cnt_q <= '0;
          if (state_q == DATA) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign tx = tx_q;

endmodule
